// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared types and constants for the register-specified shift sequencer.
//   sh_type_t   : ARM shift encoding (LSL/LSR/ASR/ROR)
//   seq_state_t : sequencer FSM states
//   AMT_W       : width of the shift-amount field (Rs[7:0])
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int AMT_W = 8;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_type_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational barrel stage: shifts a 32-bit value by 0..31 bits of one ARM
// shift type and produces the carry (last bit shifted out).
// Ports:
//   i_value  [31:0] value to shift
//   i_type   [1:0]  shift type (sh_type_t)
//   i_k      [4:0]  bits to shift this step; 0 leaves value and carry untouched
//   i_rrx           rotate-right-extended: ignores i_k, shifts in i_carry
//   i_carry         incoming carry flag
//   o_value  [31:0] shifted value
//   o_carry         resulting carry
// -----------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
(
  input  logic [31:0] i_value,
  input  sh_type_t    i_type,
  input  logic [4:0]  i_k,
  input  logic        i_rrx,
  input  logic        i_carry,
  output logic [31:0] o_value,
  output logic        o_carry
);

  // One guard bit beside the value catches the last bit shifted out, so the
  // carry never needs a variable bit-select.
  logic        [32:0] w_lsl;
  logic        [32:0] w_lsr;
  logic signed [32:0] w_asr;
  logic        [31:0] w_ror;

  assign w_lsl = {1'b0, i_value} << i_k;
  assign w_lsr = {i_value, 1'b0} >> i_k;
  assign w_asr = $signed({i_value, 1'b0}) >>> i_k;
  // For k==0 the left half shifts by 32 and vanishes, giving the value back.
  assign w_ror = (i_value >> i_k) | (i_value << (6'd32 - {1'b0, i_k}));

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs -- no latch.
    o_value = i_value;
    o_carry = i_carry;
    if (i_rrx) begin
      o_value = {i_carry, i_value[31:1]};
      o_carry = i_value[0];
    end else if (i_k != 5'd0) begin
      unique case (i_type)
        SH_LSL: begin o_value = w_lsl[31:0];  o_carry = w_lsl[32]; end
        SH_LSR: begin o_value = w_lsr[32:1];  o_carry = w_lsr[0];  end
        SH_ASR: begin o_value = w_asr[32:1];  o_carry = w_asr[0];  end
        SH_ROR: begin o_value = w_ror;        o_carry = w_ror[31]; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle controller for ARM shift-by-register (amount = Rs[7:0]).
// Iterates a bounded barrel stage (shift_step) at most MAX_STEP bits per cycle
// until the full 0..255 amount is applied; gives the ARM-exact result and
// shifter carry-out. Valid/ready handshake on request and result sides.
// Parameters:
//   MAX_STEP  max bits shifted per SHIFT cycle, 1..31
// Ports:
//   clk, reset (synchronous, active high)
//   req_valid / req_ready   request handshake (ready only in IDLE)
//   op_value, sh_type, amount, carry_in   request fields, sampled at accept
//   res_valid / res_ready   result handshake (valid only in DONE)
//   result, carry_out       shifted value and shifter carry
// Configuration:
//   SHIFT_SEQ_RRX_EN  when defined, ROR by 0 is RRX (one SHIFT cycle);
//                     otherwise ROR by 0 passes the value and carry through.
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int MAX_STEP = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] op_value,
  input  logic [1:0]  sh_type,
  input  logic [7:0]  amount,
  input  logic        carry_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] result,
  output logic        carry_out
);

  localparam logic [AMT_W-1:0] MAX_STEP_A = AMT_W'(MAX_STEP);

  seq_state_t       r_state;
  logic [31:0]      r_value;
  sh_type_t         r_type;
  logic             r_carry;
  logic [AMT_W-1:0] r_remaining;
  logic             r_rrx;

  logic [AMT_W-1:0] w_eff;
  logic             w_rrx_req;
  logic [4:0]       w_k;
  logic [31:0]      w_step_value;
  logic             w_step_carry;
  sh_type_t         w_req_type;

  assign w_req_type = sh_type_t'(sh_type);

  // ROR only cares about the rotation modulo 32.
  assign w_eff = (w_req_type == SH_ROR) ? {3'b000, amount[4:0]} : amount;

`ifdef SHIFT_SEQ_RRX_EN
  assign w_rrx_req = (w_req_type == SH_ROR) && (amount == 8'd0);
`else
  assign w_rrx_req = 1'b0;
`endif

  // Step size never exceeds what is left, so remaining cannot underflow.
  assign w_k = (r_remaining > MAX_STEP_A) ? MAX_STEP_A[4:0] : r_remaining[4:0];

  shift_step u_step (
    .i_value (r_value),
    .i_type  (r_type),
    .i_k     (w_k),
    .i_rrx   (r_rrx),
    .i_carry (r_carry),
    .o_value (w_step_value),
    .o_carry (w_step_carry)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_value     <= '0;
      r_type      <= SH_LSL;
      r_carry     <= 1'b0;
      r_remaining <= '0;
      r_rrx       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_value <= op_value;
            r_type  <= w_req_type;
            r_carry <= carry_in;
            r_rrx   <= 1'b0;
            if (w_rrx_req) begin
              // RRX is a single fixed step; remaining=1 lets SHIFT finish it.
              r_rrx       <= 1'b1;
              r_remaining <= AMT_W'(1);
              r_state     <= S_SHIFT;
            end else if (w_eff == '0) begin
              // ROR by a non-zero multiple of 32: value intact, C = bit 31.
              if (w_req_type == SH_ROR && amount != 8'd0) r_carry <= op_value[31];
              r_state <= S_DONE;
            end else begin
              r_remaining <= w_eff;
              r_state     <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_value     <= w_step_value;
          r_carry     <= w_step_carry;
          r_rrx       <= 1'b0;
          r_remaining <= r_remaining - {3'b000, w_k};
          if (r_remaining == {3'b000, w_k}) r_state <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign res_valid = (r_state == S_DONE);
  assign result    = r_value;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Two sequencer instances: [0] with MAX_STEP=31, [1] with MAX_STEP=4. Directed
// cases plus randomized requests are compared against an ARM-semantics model.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  localparam int MS0 = 31;
  localparam int MS1 = 4;

  logic        clk = 1'b0;
  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] op_value  [2];
  logic [1:0]  sh_type   [2];
  logic [7:0]  amount    [2];
  logic        carry_in  [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic [31:0] result    [2];
  logic        carry_out [2];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.MAX_STEP(MS0)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .op_value(op_value[0]), .sh_type(sh_type[0]), .amount(amount[0]), .carry_in(carry_in[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .result(result[0]), .carry_out(carry_out[0])
  );

  shift_sequencer #(.MAX_STEP(MS1)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .op_value(op_value[1]), .sh_type(sh_type[1]), .amount(amount[1]), .carry_in(carry_in[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .result(result[1]), .carry_out(carry_out[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ARM shift-by-register semantics, straight from the architectural rules.
  task automatic model(input logic [31:0] v, input logic [1:0] t, input logic [7:0] a,
                       input logic c, input int ms,
                       output logic [31:0] r, output logic co, output int lat);
    int n = int'(a);
    int eff;
    bit rrx = 1'b0;
    r  = v;
    co = c;
    case (t)
      2'd0: if (n > 0) begin
        if (n < 32)       begin r = v << n; co = v[32-n]; end
        else if (n == 32) begin r = 0;      co = v[0];    end
        else              begin r = 0;      co = 1'b0;    end
      end
      2'd1: if (n > 0) begin
        if (n < 32)       begin r = v >> n; co = v[n-1];  end
        else if (n == 32) begin r = 0;      co = v[31];   end
        else              begin r = 0;      co = 1'b0;    end
      end
      2'd2: if (n > 0) begin
        if (n < 32) begin r = 32'($signed(v) >>> n); co = v[n-1]; end
        else        begin r = {32{v[31]}};           co = v[31];  end
      end
      default: begin
        if (n == 0) begin
`ifdef SHIFT_SEQ_RRX_EN
          r = {c, v[31:1]}; co = v[0]; rrx = 1'b1;
`endif
        end else if (n % 32 == 0) begin
          co = v[31];
        end else begin
          r = (v >> (n % 32)) | (v << (32 - n % 32));
          co = r[31];
        end
      end
    endcase
    eff = (t == 2'd3) ? n % 32 : n;
    if (rrx)           lat = 2;
    else if (eff == 0) lat = 1;
    else               lat = 1 + (eff + ms - 1) / ms;
  endtask

  task automatic do_op(input int s, input string name, input logic [31:0] v,
                       input logic [1:0] t, input logic [7:0] a, input logic c, input int hold);
    logic [31:0] er;
    logic        ec;
    int          elat;
    int          n;
    model(v, t, a, c, (s == 0) ? MS0 : MS1, er, ec, elat);
    n = 0;
    while (!req_ready[s] && n < 400) begin @(posedge clk); #1; n++; end
    check({name, " req_ready"}, 64'(req_ready[s]), 64'd1);
    op_value[s] = v; sh_type[s] = t; amount[s] = a; carry_in[s] = c;
    req_valid[s] = 1'b1;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    // Scramble inputs: only the accept-cycle values may matter.
    op_value[s] = $urandom; sh_type[s] = 2'($urandom); amount[s] = 8'($urandom); carry_in[s] = 1'($urandom);
    n = 1;
    while (!res_valid[s] && n < 400) begin @(posedge clk); #1; n++; end
    check({name, " latency"}, 64'(n), 64'(elat));
    check({name, " result"}, 64'(result[s]), 64'(er));
    check({name, " carry"}, 64'(carry_out[s]), 64'(ec));
    for (int i = 0; i < hold; i++) begin
      req_valid[s] = 1'b1;
      @(posedge clk); #1;
      check({name, " hold valid"}, 64'(res_valid[s]), 64'd1);
      check({name, " hold ready"}, 64'(req_ready[s]), 64'd0);
      check({name, " hold result"}, 64'(result[s]), 64'(er));
      check({name, " hold carry"}, 64'(carry_out[s]), 64'(ec));
    end
    req_valid[s] = 1'b0;
    res_ready[s] = 1'b1;
    @(posedge clk); #1;
    res_ready[s] = 1'b0;
    check({name, " handoff valid"}, 64'(res_valid[s]), 64'd0);
    check({name, " handoff ready"}, 64'(req_ready[s]), 64'd1);
  endtask

  logic [7:0] ra;
  bit         seen_valid;

  initial begin
    for (int s = 0; s < 2; s++) begin
      reset[s] = 1'b1; req_valid[s] = 1'b0; op_value[s] = '0; sh_type[s] = '0;
      amount[s] = '0; carry_in[s] = 1'b0; res_ready[s] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset req_ready", 64'(req_ready[s]), 64'd1);
      check("reset res_valid", 64'(res_valid[s]), 64'd0);
      check("reset result",    64'(result[s]),    64'd0);
      check("reset carry",     64'(carry_out[s]), 64'd0);
      reset[s] = 1'b0;
    end

    // Directed cases (instance with MAX_STEP=31).
    do_op(0, "lsl1by4",   32'h0000_0001, 2'd0, 8'd4,   1'b1, 0);
    check("lsl1by4 value", 64'(result[0]), 64'h10);
    do_op(0, "lsr_by32",  32'h8000_0000, 2'd1, 8'd32,  1'b0, 0);
    do_op(0, "asr_by200", 32'h8000_0000, 2'd2, 8'd200, 1'b0, 0);
    do_op(0, "ror_by36",  32'h0000_00F1, 2'd3, 8'd36,  1'b1, 0);
    do_op(0, "ror_by32",  32'h8000_0001, 2'd3, 8'd32,  1'b0, 0);
    do_op(0, "lsl_by0",   32'h1234_5678, 2'd0, 8'd0,   1'b1, 0);
    do_op(0, "ror_by0",   32'h0000_0003, 2'd3, 8'd0,   1'b1, 0);
    do_op(0, "stall5",    32'hDEAD_BEEF, 2'd2, 8'd7,   1'b0, 5);

    // Reset in the middle of a long LSL on the MAX_STEP=4 instance.
    op_value[1] = 32'hFFFF_FFFF; sh_type[1] = 2'd0; amount[1] = 8'd255; carry_in[1] = 1'b0;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset[1] = 1'b1;
    @(posedge clk); #1;
    reset[1] = 1'b0;
    check("midreset req_ready", 64'(req_ready[1]), 64'd1);
    check("midreset res_valid", 64'(res_valid[1]), 64'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (res_valid[1]) seen_valid = 1'b1;
    end
    check("midreset no result", 64'(seen_valid), 64'd0);
    do_op(1, "after_reset", 32'h0000_0081, 2'd0, 8'd9, 1'b0, 1);

    // Randomized requests on both instances.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(0, 5))
          0:       ra = 8'd0;
          1:       ra = 8'd32;
          2:       ra = 8'($urandom_range(1, 31));
          3:       ra = 8'($urandom_range(33, 255));
          4:       ra = ($urandom_range(0, 1) != 0) ? 8'd64 : 8'd255;
          default: ra = 8'($urandom);
        endcase
        do_op(s, (s == 0) ? "rand_ms31" : "rand_ms4", $urandom, 2'($urandom), ra,
              1'($urandom), $urandom_range(0, 2));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
